// File: rtl/arm_exec_monitor.sv
// ----------------------------------------------------------------------------
// arm_exec_monitor
// Execution monitor that sits beside the single-cycle ARM core. Each enabled
// cycle it samples the executing instruction, its PC, the ALU op and the ALU
// result, keeps saturating statistics, detects the end-of-program sentinel
// (HALT_REPEAT consecutive samples of HALT_INSTR) and flags a watchdog
// timeout after TIMEOUT sampled RUN cycles. All outputs are registered.
//
// Ports
//   CLK, RST     clock (rising edge), synchronous active-high reset
//   en           sample enable; when low every register holds
//   clr          synchronous soft clear, same effect as RST (lower priority)
//   Instr, PC    instruction executing this cycle and its PC
//   ALUResult    ALU output this cycle
//   ALUControl   ALU op this cycle (selects the histogram bin)
//   done         sentinel condition met (sticky until RST/clr)
//   timeout      watchdog expired (sticky until RST/clr)
//   running      monitor is in the RUN state
//   cycle_count  sampled RUN cycles
//   instr_count  non-sentinel instructions sampled
//   zero_count   non-sentinel samples whose ALUResult was zero
//   op_count     per-op histogram, bin i at [i*CNT_W +: CNT_W]
//   last_pc      PC of the most recent non-sentinel sample
// ----------------------------------------------------------------------------
module arm_exec_monitor #(
    parameter int                DATA_W      = 32,
    parameter int                OP_W        = 2,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] HALT_INSTR  = 32'hE0000000,
    parameter int                HALT_REPEAT = 1,
    parameter int                TIMEOUT     = 1000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        en,
    input  logic                        clr,
    input  logic [DATA_W-1:0]           Instr,
    input  logic [DATA_W-1:0]           PC,
    input  logic [DATA_W-1:0]           ALUResult,
    input  logic [OP_W-1:0]             ALUControl,
    output logic                        done,
    output logic                        timeout,
    output logic                        running,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            instr_count,
    output logic [CNT_W-1:0]            zero_count,
    output logic [(2**OP_W)*CNT_W-1:0]  op_count,
    output logic [DATA_W-1:0]           last_pc
);

    localparam int NUM_OPS = 2**OP_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    state_t           state_r;
    logic [3:0]       rep_r;
    logic [CNT_W-1:0] op_cnt_r [NUM_OPS];

    logic             sampling_s;
    logic             is_halt_s;
    logic [3:0]       rep_inc_s;
    logic [CNT_W-1:0] cyc_inc_s;
    logic             done_hit_s;
    logic             tmo_hit_s;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Flatten the histogram bins onto the op_count bus.
    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_op_bus
            assign op_count[g*CNT_W +: CNT_W] = op_cnt_r[g];
        end
    endgenerate

    // Decide whether this cycle is sampled: IDLE's first enabled cycle already
    // counts as a RUN cycle, terminal states never sample.
    always_comb begin
        sampling_s = 1'b0;
        case (state_r)
            ST_IDLE: sampling_s = en;
            ST_RUN:  sampling_s = en;
            ST_DONE: sampling_s = 1'b0;
            ST_TMO:  sampling_s = 1'b0;
            default: sampling_s = 1'b0;
        endcase
    end

    // Sentinel and watchdog conditions for the current sample; done wins a tie.
    always_comb begin
        is_halt_s  = (Instr == HALT_INSTR);
        rep_inc_s  = rep_r + 4'd1;
        cyc_inc_s  = sat_inc(cycle_count);
        if (is_halt_s) begin
            done_hit_s = (rep_inc_s == 4'(HALT_REPEAT));
        end else begin
            done_hit_s = 1'b0;
        end
        tmo_hit_s  = (cyc_inc_s == CNT_W'(TIMEOUT)) && !done_hit_s;
    end

    // Monitor FSM with all statistics and status registered alongside it.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            state_r     <= ST_IDLE;
            rep_r       <= 4'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            running     <= 1'b0;
            cycle_count <= {CNT_W{1'b0}};
            instr_count <= {CNT_W{1'b0}};
            zero_count  <= {CNT_W{1'b0}};
            last_pc     <= {DATA_W{1'b0}};
            for (int i = 0; i < NUM_OPS; i++) begin
                op_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (sampling_s) begin
            cycle_count <= cyc_inc_s;
            if (is_halt_s) begin
                rep_r <= rep_inc_s;
            end else begin
                rep_r                <= 4'd0;
                instr_count          <= sat_inc(instr_count);
                last_pc              <= PC;
                op_cnt_r[ALUControl] <= sat_inc(op_cnt_r[ALUControl]);
                if (ALUResult == {DATA_W{1'b0}}) begin
                    zero_count <= sat_inc(zero_count);
                end else begin
                    zero_count <= zero_count;
                end
            end
            if (done_hit_s) begin
                state_r <= ST_DONE;
                done    <= 1'b1;
                running <= 1'b0;
            end else if (tmo_hit_s) begin
                state_r <= ST_TMO;
                timeout <= 1'b1;
                running <= 1'b0;
            end else begin
                state_r <= ST_RUN;
                running <= 1'b1;
            end
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: doc/arm_exec_monitor.md
# arm_exec_monitor

Synthesizable execution monitor for the single-cycle ARM core. It samples the core's per-cycle instruction, PC, ALU control and ALU result, and counts cycles, retired instructions, per-ALU-op occurrences and zero results. It detects the end-of-program sentinel instruction and flags a watchdog timeout. It sits beside the core, in both the bench and the FPGA top, and replaces ad-hoc display-based end-of-run checking with registered status a bench or debug port can read.

## Interface
- DATA_W, 32, width of Instr, PC and ALUResult
- OP_W, 2, width of ALUControl; NUM_OPS = 2**OP_W histogram bins
- CNT_W, 16, width of every counter
- HALT_INSTR, 32'hE0000000, sentinel instruction value
- HALT_REPEAT, 1, consecutive sentinel samples required to finish (1..15)
- TIMEOUT, 1000, RUN cycles before timeout is flagged (must be less than 2**CNT_W)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- en  in  1  sample enable; when low, all state holds
- clr  in  1  synchronous soft clear, same effect as RST
- Instr  in  DATA_W  instruction currently executing
- PC  in  DATA_W  PC of that instruction
- ALUResult  in  DATA_W  ALU output this cycle
- ALUControl  in  OP_W  ALU op this cycle
- done  out  1  sentinel condition met, sticky
- timeout  out  1  watchdog expired, sticky
- running  out  1  state is RUN
- cycle_count  out  CNT_W  sampled cycles in RUN, saturating
- instr_count  out  CNT_W  non-sentinel instructions sampled, saturating
- zero_count  out  CNT_W  samples with ALUResult == 0, saturating
- op_count  out  NUM_OPS*CNT_W  bin i at [i*CNT_W +: CNT_W], saturating
- last_pc  out  DATA_W  PC of the most recent non-sentinel sample

## Operation
- States: IDLE, RUN, DONE, TMO.
- RST or clr: state = IDLE. All counters, last_pc and the internal repeat counter go to 0. done, timeout and running go to 0. RST has priority over clr, and clr over everything else.
- IDLE: the first cycle with en = 1 moves to RUN. That same cycle is also sampled as a RUN cycle.
- RUN, per cycle with en = 1:
  - cycle_count += 1.
  - If Instr == HALT_INSTR, rep += 1. Otherwise rep = 0, instr_count += 1, last_pc = PC, op_count[ALUControl] += 1, and zero_count += 1 if ALUResult == 0.
  - Sentinel samples never update the op, zero or last_pc statistics.
- RUN to DONE when the sentinel sample makes rep reach HALT_REPEAT.
- RUN to TMO when cycle_count after increment equals TIMEOUT and the done condition is false.
  - If both conditions hit in the same cycle, done wins and timeout stays 0.
- DONE and TMO are terminal. Counters freeze and only RST or clr leaves them.
- Saturation: every counter stops at 2**CNT_W-1 and never wraps.
- en = 0 in any state: no counter, rep or state change.

## Timing
- All outputs are registered. Sample at rising edge N; effect visible after edge N.
- done rises on the edge that samples the HALT_REPEAT-th consecutive sentinel. running falls on that same edge.
- Latency from the first sentinel sample to done: HALT_REPEAT cycles of en = 1.
- timeout rises on the edge where cycle_count becomes TIMEOUT.
- A reset asserted mid-RUN clears everything on the next edge; no partial statistics survive.
- No combinational path from inputs to outputs.

## Test plan
- Reset and idle: RST held 3 cycles, then en = 0 for 5 cycles.
  - Required: all outputs 0, running = 0.
- Basic run: HALT_REPEAT = 1, four instructions with ALUControl 0,1,0,2 and ALUResult 5,0,0,7, then 0xE0000000.
  - Required: done = 1, cycle_count = 5, instr_count = 4, op_count bins = {2,1,1,0}, zero_count = 2, last_pc = PC of the 4th instruction.
- Repeat and stall: HALT_REPEAT = 3. Sequence: sentinel, sentinel, one non-sentinel, then three sentinels with en = 0 inserted between the 2nd and 3rd.
  - Required: done only after the third consecutive enabled sentinel; instr_count = 1.
- Timeout: TIMEOUT = 10, no sentinel.
  - Required: timeout = 1 after the 10th enabled sample, cycle_count = 10, counters frozen afterwards.
- Timeout/done collision: TIMEOUT = 5, sentinel as the 5th sample.
  - Required: done = 1, timeout = 0.
- Saturation and mid-run reset: CNT_W = 3, run 10 non-sentinel samples.
  - Required: instr_count = 7, no wrap.
  - Then assert clr for 1 cycle. Required: all counters 0, state IDLE.
